block_to_bytes_stream: RTL

- Serializer for 128-bit AES blocks; the inverse of the byte-to-block packing path.
- Accepts one 128-bit block through a valid/ready handshake and emits it as BLOCK_BYTES bytes, one per accepted beat, on a byte stream with valid/ready.
- Sits between the cipher core output and byte-wide transports (UART/FIFO); byte order matches the state packing: d00 = bits [127:120] first, d33 = bits [7:0] last.

---
 rtl/block_to_bytes_stream_if.sv | 38 +++
 rtl/block_to_bytes_stream.sv | 90 +++++++++
 2 files changed

// File: rtl/block_to_bytes_stream_if.sv
// block_to_bytes_stream_if
// Groups the block-side and byte-side handshakes of the block serializer.
//   in_block  : block to serialize, sampled only on in_valid & in_ready
//   in_valid  : in_block is valid
//   in_ready  : serializer can take a block this cycle
//   out_byte  : current byte of the held block
//   out_valid : out_byte is valid
//   out_ready : downstream accepts out_byte this cycle
//   out_idx   : position of out_byte within the block
//   out_last  : out_byte is the final byte of the block
//   busy      : a block is held (same as out_valid)
// Modports: master = the side feeding blocks and draining bytes,
//           slave  = the serializer itself.
interface block_to_bytes_stream_if #(
  parameter int BLOCK_BYTES = 16
);
  localparam int BW = 8 * BLOCK_BYTES;

  logic [BW-1:0] in_block;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_byte;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_idx;
  logic          out_last;
  logic          busy;

  modport master (
    output in_block, in_valid, out_ready,
    input  in_ready, out_byte, out_valid, out_idx, out_last, busy
  );

  modport slave (
    input  in_block, in_valid, out_ready,
    output in_ready, out_byte, out_valid, out_idx, out_last, busy
  );
endinterface

// File: rtl/block_to_bytes_stream.sv
// block_to_bytes_stream
// Serializes one AES block into BLOCK_BYTES bytes on a valid/ready byte
// stream. With MSB_FIRST=1 the byte order follows the state packing
// (bits [127:120] first, bits [7:0] last); MSB_FIRST=0 reverses it.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : block_to_bytes_stream_if.slave (block in, byte stream out)
module block_to_bytes_stream #(
  parameter int BLOCK_BYTES = 16,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  block_to_bytes_stream_if.slave        bus
);
  localparam int BW = 8 * BLOCK_BYTES;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  localparam logic [3:0] IDX_LAST = 4'(BLOCK_BYTES - 1);

  // out_idx is 4 bits wide, so blocks larger than 16 bytes cannot be indexed.
  generate
    if (BLOCK_BYTES < 1 || BLOCK_BYTES > 16) begin : g_bad_block_bytes
      $error("block_to_bytes_stream: BLOCK_BYTES must be in 1..16");
    end
  endgenerate

  logic [0:0]    state_q, state_d;
  logic [BW-1:0] shift_q, shift_d;
  logic [3:0]    idx_q,   idx_d;

  logic          last;
  logic          in_ready;

  assign last     = (state_q == SEND) && (idx_q == IDX_LAST);
  // Taking a new block while the last byte leaves lets blocks run back to
  // back with no idle beat between them.
  assign in_ready = (state_q == IDLE) || (last && bus.out_ready);

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == SEND);
  assign bus.busy      = (state_q == SEND);
  assign bus.out_idx   = idx_q;
  assign bus.out_last  = last;
  // The byte comes from the registered head of the shift register, so a
  // changing in_block never leaks onto out_byte.
  assign bus.out_byte  = MSB_FIRST ? shift_q[BW-1 -: 8] : shift_q[7:0];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    if (state_q == IDLE) begin
      if (bus.in_valid) begin
        state_d = SEND;
        shift_d = bus.in_block;
        idx_d   = 4'd0;
      end
    end else if (bus.out_ready) begin
      if (!last) begin
        // Move the next byte into the head position.
        shift_d = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
        idx_d   = idx_q + 4'd1;
      end else if (bus.in_valid) begin
        shift_d = bus.in_block;
        idx_d   = 4'd0;
      end else begin
        // Clearing the register keeps out_byte at zero while idle.
        state_d = IDLE;
        shift_d = '0;
        idx_d   = 4'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end
endmodule
